// File: rtl/mod_74xx_pkg.sv
// mod_74xx_pkg
// Shared constants for the 74xx-style counter slices and their chains.
//   SLICE_W    : width of one counter slice
//   SLICE_MAX  : terminal count of one slice (drives the slice ripple carry)
//   cnt_mode_e : what a slice does at a rising clock edge
package mod_74xx_pkg;

  localparam int unsigned    SLICE_W   = 4;
  localparam logic [3:0]     SLICE_MAX = 4'hF;

  typedef enum logic [1:0] {
    MODE_CLR   = 2'd0,
    MODE_LOAD  = 2'd1,
    MODE_COUNT = 2'd2,
    MODE_HOLD  = 2'd3
  } cnt_mode_e;

endpackage

// File: rtl/mod_74x161_slice.sv
// mod_74x161_slice
// One 4-bit synchronous binary counter slice in the style of a 74x161.
// Optional macro MOD_74X161_SYNC_CLR_EN adds a synchronous clear (74x163 variant).
// Ports:
//   CLK     rising-edge clock
//   CLR_N   asynchronous active-low clear
//   SCLR_N  synchronous active-low clear (only with MOD_74X161_SYNC_CLR_EN)
//   LOAD_N  synchronous active-low parallel load
//   ENP     count enable P
//   ENT     count enable T (also gates RCO)
//   D       parallel load data
//   Q       counter value
//   RCO     ripple-carry out: ENT & (Q == 4'hF)
module mod_74x161_slice
  import mod_74xx_pkg::*;
(
  input  logic               CLK,
  input  logic               CLR_N,
`ifdef MOD_74X161_SYNC_CLR_EN
  input  logic               SCLR_N,
`endif
  input  logic               LOAD_N,
  input  logic               ENP,
  input  logic               ENT,
  input  logic [SLICE_W-1:0] D,
  output logic [SLICE_W-1:0] Q,
  output logic               RCO
);

  logic [SLICE_W-1:0] q_q;
  logic [SLICE_W-1:0] q_d;
  cnt_mode_e          mode;
  logic               sclr_n;

`ifdef MOD_74X161_SYNC_CLR_EN
  assign sclr_n = SCLR_N;
`else
  assign sclr_n = 1'b1;
`endif

  always_comb begin
    mode = MODE_HOLD;
    if (!sclr_n)
      mode = MODE_CLR;
    else if (!LOAD_N)
      mode = MODE_LOAD;
    else if (ENP && ENT)
      mode = MODE_COUNT;
  end

  always_comb begin
    q_d = q_q;
    case (mode)
      MODE_CLR:   q_d = '0;
      MODE_LOAD:  q_d = D;
      MODE_COUNT: q_d = q_q + 4'd1;
      default:    q_d = q_q;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N)
      q_q <= '0;
    else
      q_q <= q_d;
  end

  assign Q = q_q;

  // ENP deliberately does not gate the carry, as on the real part.
  assign RCO = ENT & (q_q == SLICE_MAX);

endmodule

// File: rtl/mod_74x161_chain.sv
// mod_74x161_chain
// SLICES cascaded 4-bit counter slices, RCO of slice k feeding ENT of slice k+1,
// forming a 4*SLICES-bit synchronous counter. SLICES legal range is 1..8.
// Optional macro MOD_74X161_SYNC_CLR_EN adds the SCLR_N synchronous clear.
// Ports:
//   CLK     rising-edge clock
//   CLR_N   asynchronous active-low clear (all slices)
//   SCLR_N  synchronous active-low clear (only with MOD_74X161_SYNC_CLR_EN)
//   LOAD_N  synchronous active-low parallel load (all slices, same edge)
//   ENP     count enable P, common to all slices
//   ENT     count enable T, slice 0 only
//   D       parallel load data, D[3:0] = slice 0
//   Q       counter value, Q[3:0] = slice 0
//   RCO     ripple-carry out of the most significant slice
module mod_74x161_chain
  import mod_74xx_pkg::*;
#(
  parameter int unsigned SLICES = 2
) (
  input  logic                      CLK,
  input  logic                      CLR_N,
`ifdef MOD_74X161_SYNC_CLR_EN
  input  logic                      SCLR_N,
`endif
  input  logic                      LOAD_N,
  input  logic                      ENP,
  input  logic                      ENT,
  input  logic [SLICE_W*SLICES-1:0] D,
  output logic [SLICE_W*SLICES-1:0] Q,
  output logic                      RCO
);

  // ent_chain[k] is the ENT seen by slice k; the last entry is the top carry.
  logic [SLICES:0] ent_chain;

  assign ent_chain[0] = ENT;

  for (genvar k = 0; k < SLICES; k++) begin : g_slice
    mod_74x161_slice u_slice (
      .CLK    (CLK),
      .CLR_N  (CLR_N),
`ifdef MOD_74X161_SYNC_CLR_EN
      .SCLR_N (SCLR_N),
`endif
      .LOAD_N (LOAD_N),
      .ENP    (ENP),
      .ENT    (ent_chain[k]),
      .D      (D[k*SLICE_W +: SLICE_W]),
      .Q      (Q[k*SLICE_W +: SLICE_W]),
      .RCO    (ent_chain[k+1])
    );
  end

  assign RCO = ent_chain[SLICES];

endmodule

// File: tb/tb_mod_74x161_chain.sv
module tb_mod_74x161_chain;
  import mod_74xx_pkg::*;

  localparam int SLICES = 2;
  localparam int W      = 4 * SLICES;

  logic         CLK = 1'b0;
  logic         CLR_N = 1'b0;
  logic         LOAD_N = 1'b1;
  logic         ENP = 1'b0;
  logic         ENT = 1'b0;
  logic [W-1:0] D = '0;
  logic [W-1:0] Q;
  logic         RCO;
`ifdef MOD_74X161_SYNC_CLR_EN
  logic         SCLR_N = 1'b1;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  // Reference: the chain as one W-bit integer counter.
  logic [W-1:0] exp_q = '0;

  mod_74x161_chain #(.SLICES(SLICES)) u_dut (
    .CLK    (CLK),
    .CLR_N  (CLR_N),
`ifdef MOD_74X161_SYNC_CLR_EN
    .SCLR_N (SCLR_N),
`endif
    .LOAD_N (LOAD_N),
    .ENP    (ENP),
    .ENT    (ENT),
    .D      (D),
    .Q      (Q),
    .RCO    (RCO)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
    else
      n_pass++;
  endtask

  function automatic logic exp_rco();
    return ENT && (exp_q == {W{1'b1}});
  endfunction

  // One rising edge: advance the model, then check the DUT 1 time unit later.
  task automatic step(input string tag);
    cnt_mode_e m;
    logic sclr;
    @(posedge CLK);
`ifdef MOD_74X161_SYNC_CLR_EN
    sclr = SCLR_N;
`else
    sclr = 1'b1;
`endif
    if (!CLR_N || !sclr)          m = MODE_CLR;
    else if (!LOAD_N)             m = MODE_LOAD;
    else if (ENP && ENT)          m = MODE_COUNT;
    else                          m = MODE_HOLD;
    case (m)
      MODE_CLR:   exp_q = '0;
      MODE_LOAD:  exp_q = D;
      MODE_COUNT: exp_q = W'((int'(exp_q) + 1) % (1 << W));
      default:    ;
    endcase
    #1;
    chk({tag, "_q"}, 32'(Q), 32'(exp_q));
    chk({tag, "_rco"}, 32'(RCO), 32'(exp_rco()));
    @(negedge CLK);
  endtask

  task automatic drive(input logic load_n, input logic enp, input logic ent, input logic [W-1:0] d);
    LOAD_N = load_n;
    ENP    = enp;
    ENT    = ent;
    D      = d;
  endtask

  int pulses;

  initial begin
    #1;
    chk("reset_q", 32'(Q), 32'h0);
    chk("reset_rco", 32'(RCO), 32'h0);
    @(negedge CLK);
    CLR_N = 1'b1;

    // Async clear mid-cycle, then held low for three clocks.
    drive(1'b0, 1'b1, 1'b1, 8'h36); step("ld36");
    drive(1'b1, 1'b1, 1'b1, 8'h00); step("cnt37");
    #2; CLR_N = 1'b0; #1;
    exp_q = '0;
    chk("async_clr_q", 32'(Q), 32'h00);
    for (int i = 0; i < 3; i++) step("clr_hold");
    CLR_N = 1'b1;

    // Load wins over count.
    drive(1'b0, 1'b1, 1'b1, 8'hA5); step("ld_prio");
    chk("ld_prio_val", 32'(Q), 32'hA5);
    drive(1'b1, 1'b1, 1'b1, 8'h00); step("after_ld");
    chk("after_ld_val", 32'(Q), 32'hA6);

    // Cascade carry between slices and at the top.
    drive(1'b0, 1'b1, 1'b1, 8'h0E); step("ld0e");
    drive(1'b1, 1'b1, 1'b1, 8'h00); step("cnt0f");
    chk("slice0_rco", 32'(u_dut.g_slice[0].u_slice.RCO), 32'h1);
    step("cnt10");
    chk("cnt10_val", 32'(Q), 32'h10);
    drive(1'b0, 1'b1, 1'b1, 8'hFE); step("ldfe");
    drive(1'b1, 1'b1, 1'b1, 8'h00); step("cntff");
    chk("top_rco_ff", 32'(RCO), 32'h1);
    step("wrap00");
    chk("wrap_rco", 32'(RCO), 32'h0);

    // Enable gating.
    drive(1'b0, 1'b1, 1'b1, 8'hFF); step("ldff");
    drive(1'b1, 1'b0, 1'b1, 8'h00); step("enp0_hold");
    chk("enp0_rco", 32'(RCO), 32'h1);
    ENT = 1'b0; #1;
    chk("ent0_rco_comb", 32'(RCO), 32'h0);
    ENP = 1'b1; step("ent0_hold");

    // Free run: 256 edges from zero, one RCO pulse.
    drive(1'b0, 1'b1, 1'b1, 8'h00); step("ld00");
    drive(1'b1, 1'b1, 1'b1, 8'h00);
    pulses = 0;
    for (int i = 0; i < 256; i++) begin
      step("free");
      if (RCO) pulses++;
    end
    chk("free_end", 32'(Q), 32'h00);
    chk("free_pulses", 32'(pulses), 32'd1);

`ifdef MOD_74X161_SYNC_CLR_EN
    drive(1'b0, 1'b1, 1'b1, 8'h42); step("ld42");
    SCLR_N = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 8'h99); #1;
    chk("sclr_before", 32'(Q), 32'h42);
    step("sclr_edge");
    chk("sclr_after", 32'(Q), 32'h00);
    SCLR_N = 1'b1;
`endif

    // Randomized traffic against the integer model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0), W'($urandom));
`ifdef MOD_74X161_SYNC_CLR_EN
      SCLR_N = ($urandom_range(0, 15) != 0);
`endif
      if ($urandom_range(0, 24) == 0) begin
        CLR_N = 1'b0; #1;
        exp_q = '0;
        chk("rnd_async_clr", 32'(Q), 32'h0);
        CLR_N = 1'b1;
      end
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mod_74x161_chain.md
Name: mod_74x161_chain

Overview:
- Cascadable synchronous 4-bit binary counter modelled on the 74x161: asynchronous clear, synchronous parallel load, and count enables ENP/ENT with ripple-carry output RCO.
- SLICES counter slices are chained RCO-to-ENT to form a wider counter, as on a board.
- Sits downstream of the MOD_74x32 OR-gate stage. That stage's Y outputs drive LOAD_N, ENP and ENT (combined load and enable terms).

Parameters:
- SLICES, 2, number of chained 4-bit slices; counter width is 4*SLICES; legal range 1..8.

Ports:
- CLK  input  1  rising-edge clock.
- CLR_N  input  1  asynchronous active-low clear.
- LOAD_N  input  1  synchronous active-low parallel load.
- ENP  input  1  count-enable P; common to all slices.
- ENT  input  1  count-enable T; feeds slice 0 only.
- D  input  4*SLICES  parallel load data; D[3:0] belongs to slice 0 (LSB).
- Q  output  4*SLICES  counter value; Q[3:0] is the LSB slice.
- RCO  output  1  ripple-carry out of the most significant slice.
- SCLR_N  input  1  present only with MOD_74X161_SYNC_CLR_EN (see Optional Feature).

Behaviour:
- Reset:
  - One clock, CLK; reset is asynchronous and active-low, CLR_N.
  - CLR_N=0 forces Q=0 immediately, independent of CLK, and holds Q at 0 while low.
  - RCO follows combinationally and reads 0 while Q=0, unless SLICES... (no exception: Q=0 is never all ones, so RCO=0).
  - Deassertion of CLR_N takes effect at the next rising CLK; there is no synchronizer inside.
- Per-slice priority at each rising CLK edge with CLR_N=1:
  - LOAD_N=0: Q_slice <= D_slice. The load ignores ENP/ENT and applies to all slices in the same edge.
  - Otherwise, if ENP=1 and ENT_slice=1: Q_slice <= Q_slice+1, mod 16.
  - Otherwise: hold.
- Slice carry:
  - RCO_slice = ENT_slice & (Q_slice==4'hF), purely combinational.
  - ENT of slice k (k>0) = RCO of slice k-1.
  - Top-level RCO = RCO of slice SLICES-1.
- Whole counter:
  - Counts 0 .. 2^(4*SLICES)-1 and wraps to 0 with no sticky flag.
  - Latency: Q updates one edge after the enable/load conditions; no pipelining.
- RCO at terminal count:
  - RCO is high in the cycle where Q is all ones and ENT=1.
  - ENP does not gate RCO, matching the 74x161.
- Simultaneous events:
  - CLR_N low at a clock edge wins over load and count.
  - Load wins over count.
  - ENT=0 freezes all slices, because carry propagates only through ENT.
  - ENP=0 freezes all slices, while RCO remains valid.
- Reset mid-operation: an asynchronous clear during counting or loading zeroes Q in the same timestep, and no partial load survives.
- Inputs are treated as 2-state. An X on LOAD_N/ENP/ENT produces an X on Q per standard simulator semantics; no X-scrubbing.

Optional Feature:
- Macro: MOD_74X161_SYNC_CLR_EN.
- Defined (74x163 variant):
  - Adds input SCLR_N.
  - SCLR_N=0 at a rising CLK sets Q=0.
  - Priority: CLR_N async > SCLR_N > LOAD_N > count.
- Undefined: port SCLR_N does not exist; behaviour is exactly as above.
- The asynchronous CLR_N is present in both builds.

Decomposition:
- Shared package/include mod_74xx_pkg:
  - localparam SLICE_W=4.
  - localparam SLICE_MAX=4'hF.
  - Count-mode encoding constants (CLR, LOAD, COUNT, HOLD) used by the bench scoreboard.
- Sub-module mod_74x161_slice:
  - One 4-bit counter with CLK, CLR_N, [SCLR_N], LOAD_N, ENP, ENT, D[3:0], Q[3:0], RCO.
  - Top level generates SLICES instances and the RCO->ENT chain.

Test Plan:
- Async clear: count to 8'h37, pull CLR_N low mid-cycle -> Q=8'h00 before the next edge; held at 0 for 3 clocks while low.
- Load priority: ENP=ENT=1, LOAD_N=0, D=8'hA5, one edge -> Q=8'hA5 (not 8'hA6); next edge with LOAD_N=1 -> 8'hA6.
- Cascade carry: load 8'h0E, count -> 0F (slice-0 RCO=1), 10. Then load 8'hFE -> FF with top RCO=1, then 00 with RCO=0.
- Enable gating: Q=8'hFF, ENT=1, ENP=0 -> Q holds FF, RCO=1. Set ENT=0 -> RCO=0 and Q holds.
- Free-run: 256 edges from 0 with ENP=ENT=1 -> Q returns to 8'h00; RCO pulses exactly once, at FF.
- With MOD_74X161_SYNC_CLR_EN: Q=8'h42, SCLR_N=0 and LOAD_N=0 at the same edge -> Q=8'h00 after the edge, not before it.
